// File: rtl/tmr_recovery_ctrl.sv
// TMR voter with a mismatch-episode recovery FSM (observe, resync, cooldown, quarantine).
// Optional feature macro TMR_REC_STRIKE_EN: repeated transient episodes on one replica quarantine it.
module tmr_recovery_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PERSIST_TH = 4,
  parameter int STRIKE_TH  = 3,
  parameter int COOLDOWN   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] r_a,
  input  logic [WIDTH-1:0] r_b,
  input  logic [WIDTH-1:0] r_c,
  input  logic             in_valid,
  input  logic             clear_sus,
  output logic [WIDTH-1:0] voted_out,
  output logic             fault_flag,
  output logic             resync_en,
  output logic [1:0]       resync_sel,
  output logic             sus_trojan,
  output logic [2:0]       quarantine,
  output logic             uncorrectable,
  output logic [2:0]       state
);

  // state    | meaning
  // MONITOR  | all replicas agree, waiting for a mismatch episode
  // OBSERVE  | one replica (bad_id) differs, counting persistence
  // RESYNC   | single cycle reload command for bad_id
  // COOLDOWN | fixed settle window after resync, no new episodes
  // SUSPECT  | bad_id quarantined, voting on the remaining pair
  // FAIL     | no majority available, sticky until clear_sus
  typedef enum logic [2:0] {
    ST_MONITOR  = 3'd0,
    ST_OBSERVE  = 3'd1,
    ST_RESYNC   = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_SUSPECT  = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  localparam int PW = $clog2(PERSIST_TH + 1);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [PW-1:0] PERSIST_MAX = PW'(PERSIST_TH);
  localparam logic [CW-1:0] CD_LOAD     = CW'(COOLDOWN - 1);

  state_t          state_q, state_d;
  logic [1:0]      bad_q, bad_d;
  logic [PW-1:0]   persist_q, persist_d, persist_inc;
  logic [CW-1:0]   cd_q, cd_d;
  logic [2:0]      quar_q, quar_d;
  logic            sus_q, sus_d;
  logic            unc_q, unc_d;

  logic            eq_ab, eq_bc, eq_ac;
  logic            cls_none, cls_triple, cls_single;
  logic [1:0]      single_id;
  logic            pair_diff;
  logic [WIDTH-1:0] majority, pair_val, vote_d;

`ifdef TMR_REC_STRIKE_EN
  localparam int SW = $clog2(STRIKE_TH + 1);
  localparam logic [SW-1:0] STRIKE_MAX = SW'(STRIKE_TH);
  logic [2:0][SW-1:0] strike_q, strike_d;
  logic [SW-1:0]      strike_inc;

  assign strike_inc = (strike_q[bad_q] == STRIKE_MAX) ? strike_q[bad_q]
                                                      : strike_q[bad_q] + 1'b1;
`endif

  assign eq_ab      = (r_a == r_b);
  assign eq_bc      = (r_b == r_c);
  assign eq_ac      = (r_a == r_c);
  assign cls_none   = eq_ab & eq_bc;
  assign cls_triple = ~eq_ab & ~eq_bc & ~eq_ac;
  assign cls_single = ~cls_none & ~cls_triple;
  assign majority   = (r_a & r_b) | (r_a & r_c) | (r_b & r_c);

  always_comb begin
    single_id = 2'd2;
    if (eq_bc)      single_id = 2'd0;
    else if (eq_ac) single_id = 2'd1;
  end

  // With a replica quarantined only the remaining pair votes; a split pair holds the output.
  always_comb begin
    pair_diff = 1'b0;
    pair_val  = majority;
    if (quar_q[0]) begin
      pair_diff = ~eq_bc;
      pair_val  = r_b;
    end else if (quar_q[1]) begin
      pair_diff = ~eq_ac;
      pair_val  = r_a;
    end else if (quar_q[2]) begin
      pair_diff = ~eq_ab;
      pair_val  = r_a;
    end
  end

  assign vote_d      = pair_diff ? voted_out : pair_val;
  assign persist_inc = (persist_q == PERSIST_MAX) ? persist_q : persist_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bad_d     = bad_q;
    persist_d = persist_q;
    cd_d      = cd_q;
    quar_d    = quar_q;
    sus_d     = sus_q;
    unc_d     = unc_q;
`ifdef TMR_REC_STRIKE_EN
    strike_d  = strike_q;
`endif
    if (clear_sus) begin
      state_d   = ST_MONITOR;
      persist_d = '0;
      cd_d      = '0;
      quar_d    = 3'b000;
      sus_d     = 1'b0;
      unc_d     = 1'b0;
`ifdef TMR_REC_STRIKE_EN
      strike_d  = '0;
`endif
    end else if (in_valid) begin
      case (state_q)
        ST_MONITOR: begin
          if (cls_single) begin
            bad_d     = single_id;
            persist_d = PW'(1);
            state_d   = ST_OBSERVE;
          end else if (cls_triple) begin
            state_d = ST_FAIL;
          end
        end
        ST_OBSERVE: begin
          if (cls_single && (single_id == bad_q)) begin
            persist_d = persist_inc;
            if (persist_inc == PERSIST_MAX) state_d = ST_SUSPECT;
          end else if (cls_none) begin
            state_d = ST_RESYNC;
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_RESYNC: begin
          cd_d    = CD_LOAD;
          state_d = ST_COOLDOWN;
`ifdef TMR_REC_STRIKE_EN
          strike_d[bad_q] = strike_inc;
          if (strike_inc == STRIKE_MAX) state_d = ST_SUSPECT;
`endif
        end
        ST_COOLDOWN: begin
          if (cd_q == '0) state_d = ST_MONITOR;
          else            cd_d    = cd_q - 1'b1;
        end
        ST_SUSPECT: begin
          if (pair_diff) state_d = ST_FAIL;
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: state_d = ST_MONITOR;
      endcase
      if ((state_d == ST_SUSPECT) && (state_q != ST_SUSPECT)) begin
        quar_d = 3'b001 << bad_d;
        sus_d  = 1'b1;
      end
      if (state_d == ST_FAIL) unc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_MONITOR;
      bad_q     <= 2'd0;
      persist_q <= '0;
      cd_q      <= '0;
      quar_q    <= 3'b000;
      sus_q     <= 1'b0;
      unc_q     <= 1'b0;
`ifdef TMR_REC_STRIKE_EN
      strike_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bad_q     <= bad_d;
      persist_q <= persist_d;
      cd_q      <= cd_d;
      quar_q    <= quar_d;
      sus_q     <= sus_d;
      unc_q     <= unc_d;
`ifdef TMR_REC_STRIKE_EN
      strike_q  <= strike_d;
`endif
    end
  end

  // fault_flag reports the raw replica comparison even when clear_sus masks the episode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted_out  <= '0;
      fault_flag <= 1'b0;
    end else if (in_valid) begin
      voted_out  <= clear_sus ? majority : vote_d;
      fault_flag <= ~cls_none;
    end
  end

  assign state         = state_q;
  assign quarantine    = quar_q;
  assign sus_trojan    = sus_q;
  assign uncorrectable = unc_q;
  assign resync_en     = (state_q == ST_RESYNC);
  assign resync_sel    = resync_en ? bad_q : 2'b00;

endmodule
